scan_gold_checker: RTL

Parametrised multi-channel scan-chain checker: CHANNELS parallel shift chains of LENGTH bits each, with a golden snapshot register and a sequential bit-serial compare engine. Sits between the pad-level scan/gold/mux controls and the user logic under test. Generalises the single-chain scan/gold scheme to N channels, one clock domain, and adds mismatch counting with pass/fail reporting.

---
 rtl/scan_chk_pkg.sv | 26 ++
 rtl/scan_chk_popcount.sv | 17 +
 rtl/scan_gold_checker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/scan_chk_pkg.sv
// Shared types and helpers for the multi-channel scan/gold checker.
package scan_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter must hold every bit of every chain mismatching.
    function automatic int calc_cnt_w(input int channels, input int length);
        return $clog2(channels * length + 1);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/scan_chk_popcount.sv
// Combinational population count of the per-channel mismatch vector.
module scan_chk_popcount #(
    parameter int CHANNELS = 4,
    parameter int PW       = $clog2(CHANNELS + 1)
) (
    input  logic [CHANNELS-1:0] bits_in,
    output logic [PW-1:0]       count
);

    always_comb begin
        count = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            count = count + PW'(bits_in[c]);
        end
    end

endmodule

// File: rtl/scan_gold_checker.sv
// N-channel scan chains with a golden snapshot and a bit-serial compare
// engine that counts mismatches and reports pass/fail.
//
// state    | meaning
// ST_IDLE  | accepts capture/shift/load_gold/check (that priority)
// ST_CHECK | compares chain bit idx of all channels against gold each cycle
// ST_DONE  | one-cycle result pulse, then back to idle
module scan_gold_checker
    import scan_chk_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LENGTH   = 8,
    parameter int CNT_W    = calc_cnt_w(CHANNELS, LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_en,
    input  logic [CHANNELS-1:0]          scan_in,
    output logic [CHANNELS-1:0]          scan_out,
    input  logic                         capture_en,
    input  logic [CHANNELS*LENGTH-1:0]   capture_data,
    input  logic                         load_gold,
    input  logic                         check,
    input  logic                         clear_err,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_W-1:0]             err_count,
    output logic                         err_sticky
);

    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int PW    = $clog2(CHANNELS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LENGTH - 1);
    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

    state_e state_q, state_d;
    logic [CHANNELS-1:0][LENGTH-1:0] chain_q, chain_d;
    logic [CHANNELS-1:0][LENGTH-1:0] gold_q, gold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             sticky_q, sticky_d;

    logic [CHANNELS-1:0] mism;
    logic [PW-1:0]       mism_cnt;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            mism[c] = chain_q[c][idx_q] ^ gold_q[c][idx_q];
        end
    end

    scan_chk_popcount #(
        .CHANNELS (CHANNELS),
        .PW       (PW)
    ) u_popcount (
        .bits_in (mism),
        .count   (mism_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            chain_q  <= '0;
            gold_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b1;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            chain_q  <= chain_d;
            gold_q   <= gold_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!capture_en && !scan_en && !load_gold && check) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        chain_d  = chain_q;
        gold_d   = gold_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        sticky_d = sticky_q;
        if (clear_err) begin
            sticky_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (capture_en) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        chain_d[c] = capture_data[c*LENGTH +: LENGTH];
                    end
                end else if (scan_en) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        chain_d[c] = {scan_in[c], chain_q[c][LENGTH-1:1]};
                    end
                end else if (load_gold) begin
                    gold_d = chain_q;
                end else if (check) begin
                    idx_d = '0;
                    cnt_d = '0;
                end
            end
            ST_CHECK: begin
                cnt_d = CNT_W'(sat_add(32'(cnt_q), 32'(mism_cnt), CNT_MAX));
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    pass_d = (cnt_d == '0);
                    // Set on entry to DONE so the flag is visible with done.
                    if (cnt_d != '0) begin
                        sticky_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // Re-assert so a clear_err landing on the DONE cycle loses.
                if (cnt_q != '0) begin
                    sticky_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        pass       = pass_q;
        err_count  = cnt_q;
        err_sticky = sticky_q;
        for (int c = 0; c < CHANNELS; c++) begin
            scan_out[c] = chain_q[c][0];
        end
    end

endmodule
